// File: rtl/iccm_boot_loader.sv
// rtl/iccm_boot_loader.sv - UART byte stream to ICCM word loader; holds core reset until end marker.
// Optional checksum word after the marker when ICCM_BOOT_CHECKSUM_EN is defined.
module iccm_boot_loader #(
   parameter int          AddrW         = 12,
   parameter logic [31:0] EndMarker     = 32'h0000_0FFF,
   parameter int          TimeoutCycles = 100000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rx_dv_i,
   input  logic [7:0]       rx_byte_i,
   output logic             we_o,
   output logic [AddrW-1:0] addr_o,
   output logic [31:0]      wdata_o,
   output logic             sys_rst_no,
   output logic             done_o,
   output logic             err_o,
   output logic             frame_err_o,
   output logic [AddrW:0]   word_cnt_o
);

   localparam int TW = $clog2(TimeoutCycles + 1);
   localparam logic [AddrW:0] FULL_CNT = {1'b1, {AddrW{1'b0}}};

   typedef enum logic [2:0] {
      S_LOAD,
      S_WRITE,
`ifdef ICCM_BOOT_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_byte_cnt;
   logic [23:0]      r_asm;
   logic [31:0]      r_wdata;
   logic [AddrW-1:0] r_addr;
   logic [AddrW:0]   r_word_cnt;
   logic [TW-1:0]    r_tmo;
   logic             r_frame_err;
   logic             w_accept;
   logic             w_last;
   logic             w_assembling;
   logic [31:0]      w_word;
`ifdef ICCM_BOOT_CHECKSUM_EN
   logic [31:0]      r_sum;
`endif

   // A byte landing during WRITE is byte 0 of the next word, so WRITE also accepts.
   assign w_accept = rx_dv_i && (r_state == S_LOAD || r_state == S_WRITE
`ifdef ICCM_BOOT_CHECKSUM_EN
                                 || r_state == S_CSUM
`endif
                                 );
   assign w_last = w_accept && (r_byte_cnt == 2'd3);
   assign w_word = {rx_byte_i, r_asm};
`ifdef ICCM_BOOT_CHECKSUM_EN
   assign w_assembling = (r_state == S_LOAD || r_state == S_CSUM) && (r_byte_cnt != 2'd0);
`else
   assign w_assembling = (r_state == S_LOAD) && (r_byte_cnt != 2'd0);
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD: begin
            if (w_last) begin
               if (w_word == EndMarker) begin
`ifdef ICCM_BOOT_CHECKSUM_EN
                  w_next = S_CSUM;
`else
                  w_next = S_DONE;
`endif
               end else if (r_word_cnt == FULL_CNT) begin
                  w_next = S_ERR;
               end else begin
                  w_next = S_WRITE;
               end
            end
         end
         S_WRITE: w_next = S_LOAD;
`ifdef ICCM_BOOT_CHECKSUM_EN
         S_CSUM: begin
            if (w_last) w_next = (w_word == r_sum) ? S_DONE : S_ERR;
         end
`endif
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_LOAD;
         r_byte_cnt  <= 2'd0;
         r_asm       <= 24'd0;
         r_wdata     <= 32'd0;
         r_addr      <= '0;
         r_word_cnt  <= '0;
         r_tmo       <= '0;
         r_frame_err <= 1'b0;
`ifdef ICCM_BOOT_CHECKSUM_EN
         r_sum       <= 32'd0;
`endif
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            case (r_byte_cnt)
               2'd0:    r_asm[7:0]   <= rx_byte_i;
               2'd1:    r_asm[15:8]  <= rx_byte_i;
               2'd2:    r_asm[23:16] <= rx_byte_i;
               default: r_asm        <= r_asm;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_tmo      <= '0;
         end else if (w_assembling) begin
            // Stalled partial word: discard it and resync on the next byte.
            if (r_tmo == TW'(TimeoutCycles - 1)) begin
               r_byte_cnt  <= 2'd0;
               r_tmo       <= '0;
               r_frame_err <= 1'b1;
            end else begin
               r_tmo <= r_tmo + TW'(1);
            end
         end
         if (w_next == S_WRITE && r_state == S_LOAD) r_wdata <= w_word;
         if (r_state == S_WRITE) begin
            r_addr     <= r_addr + AddrW'(1);
            r_word_cnt <= r_word_cnt + (AddrW+1)'(1);
`ifdef ICCM_BOOT_CHECKSUM_EN
            r_sum      <= r_sum + r_wdata;
`endif
         end
      end
   end

   assign we_o        = (r_state == S_WRITE);
   assign addr_o      = r_addr;
   assign wdata_o     = r_wdata;
   assign done_o      = (r_state == S_DONE);
   assign err_o       = (r_state == S_ERR);
   assign sys_rst_no  = (r_state == S_DONE);
   assign frame_err_o = r_frame_err;
   assign word_cnt_o  = r_word_cnt;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// tb/tb_iccm_boot_loader.sv - directed bench for iccm_boot_loader (small ICCM, short timeout).
module tb_iccm_boot_loader;

   localparam int AW  = 2;
   localparam int TMO = 50;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_dv;
   logic [7:0]    rx_byte;
   logic          we_o;
   logic [AW-1:0] addr_o;
   logic [31:0]   wdata_o;
   logic          sys_rst_no;
   logic          done_o;
   logic          err_o;
   logic          frame_err_o;
   logic [AW:0]   word_cnt_o;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] cap_addr[$];
   logic [31:0]   cap_data[$];

   iccm_boot_loader #(.AddrW(AW), .EndMarker(32'h0000_0FFF), .TimeoutCycles(TMO)) dut (
      .clock(clk), .reset(rst), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
      .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .sys_rst_no(sys_rst_no),
      .done_o(done_o), .err_o(err_o), .frame_err_o(frame_err_o), .word_cnt_o(word_cnt_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we_o) begin
         cap_addr.push_back(addr_o);
         cap_data.push_back(wdata_o);
      end
   end

   task automatic do_reset();
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
      rst     = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cap_addr.delete();
      cap_data.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int sp);
      rx_byte = b;
      rx_dv   = 1'b1;
      @(posedge clk); #1;
      rx_dv = 1'b0;
      repeat (sp - 1) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int sp);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], sp);
   endtask

   // Last byte uses spacing 1 so the caller samples exactly one cycle after it.
   task automatic send_final(input logic [31:0] w);
      for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8], 3);
      send_byte(w[31:24], 1);
   endtask

   task automatic send_end(input logic [31:0] sum);
`ifdef ICCM_BOOT_CHECKSUM_EN
      send_word(32'h0000_0FFF, 3);
      send_final(sum);
`else
      if (sum == 32'hFFFF_FFFF) $display("note: unused sum");
      send_final(32'h0000_0FFF);
`endif
   endtask

   task automatic check_write(input int idx, input logic [AW-1:0] ea, input logic [31:0] ed);
      checks++;
      if (cap_addr.size() <= idx) begin
         failures++;
         $display("FAIL write%0d_missing: got %0d writes, need > %0d", idx, cap_addr.size(), idx);
      end else if (cap_addr[idx] !== ea || cap_data[idx] !== ed) begin
         failures++;
         $display("FAIL write%0d: addr=%0d data=%08h, expected addr=%0d data=%08h",
                  idx, cap_addr[idx], cap_data[idx], ea, ed);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({we_o, addr_o, wdata_o, sys_rst_no, done_o, err_o, frame_err_o, word_cnt_o} !== '0) begin
         failures++;
         $display("FAIL reset_state: we=%b addr=%0d wdata=%08h srn=%b done=%b err=%b ferr=%b cnt=%0d, expected all 0",
                  we_o, addr_o, wdata_o, sys_rst_no, done_o, err_o, frame_err_o, word_cnt_o);
      end
   endtask

   task automatic test_basic();
      do_reset();
      send_word(32'h1234_5678, 3);
      send_word(32'hDEAD_BEEF, 3);
      checks++;
      if (done_o !== 1'b0 || sys_rst_no !== 1'b0) begin
         failures++;
         $display("FAIL basic_pre_done: done=%b srn=%b, expected 0 0", done_o, sys_rst_no);
      end
      send_end(32'hF0E2_1567);
      checks++;
      if (done_o !== 1'b1 || sys_rst_no !== 1'b1) begin
         failures++;
         $display("FAIL basic_done: done=%b srn=%b, expected 1 1", done_o, sys_rst_no);
      end
      checks++;
      if (cap_addr.size() != 2 || word_cnt_o !== 3'd2) begin
         failures++;
         $display("FAIL basic_count: writes=%0d cnt=%0d, expected 2 2", cap_addr.size(), word_cnt_o);
      end
      check_write(0, 2'd0, 32'h1234_5678);
      check_write(1, 2'd1, 32'hDEAD_BEEF);
      send_word(32'h5555_AAAA, 3);
      checks++;
      if (cap_addr.size() != 2 || word_cnt_o !== 3'd2 || done_o !== 1'b1 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL done_ignores_rx: writes=%0d cnt=%0d done=%b err=%b, expected 2 2 1 0",
                  cap_addr.size(), word_cnt_o, done_o, err_o);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_word(32'h0302_0100, 2);
      send_word(32'h0706_0504, 2);
      send_word(32'h0B0A_0908, 2);
      send_end(32'h1310_0D0C);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (cap_addr.size() != 3 || word_cnt_o !== 3'd3 || done_o !== 1'b1) begin
         failures++;
         $display("FAIL b2b_count: writes=%0d cnt=%0d done=%b, expected 3 3 1",
                  cap_addr.size(), word_cnt_o, done_o);
      end
      check_write(0, 2'd0, 32'h0302_0100);
      check_write(1, 2'd1, 32'h0706_0504);
      check_write(2, 2'd2, 32'h0B0A_0908);
   endtask

   task automatic test_timeout();
      do_reset();
      send_byte(8'h11, 2);
      send_byte(8'h22, 2);
      repeat (TMO - 10) @(posedge clk);
      #1;
      checks++;
      if (frame_err_o !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early: frame_err=%b, expected 0", frame_err_o);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (frame_err_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout_flag: frame_err=%b, expected 1", frame_err_o);
      end
      send_word(32'hDDCC_BBAA, 3);
      repeat (2) @(posedge clk);
      #1;
      check_write(0, 2'd0, 32'hDDCC_BBAA);
      checks++;
      if (cap_addr.size() != 1 || word_cnt_o !== 3'd1 || err_o !== 1'b0 || done_o !== 1'b0) begin
         failures++;
         $display("FAIL timeout_after: writes=%0d cnt=%0d err=%b done=%b, expected 1 1 0 0",
                  cap_addr.size(), word_cnt_o, err_o, done_o);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] w;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         w = 32'hA000_0000 + i;
         send_word(w, 3);
      end
      checks++;
      if (err_o !== 1'b0 || word_cnt_o !== 3'd4) begin
         failures++;
         $display("FAIL overflow_full: err=%b cnt=%0d, expected 0 4", err_o, word_cnt_o);
      end
      send_final(32'hA000_0004);
      checks++;
      if (err_o !== 1'b1 || sys_rst_no !== 1'b0 || done_o !== 1'b0) begin
         failures++;
         $display("FAIL overflow_err: err=%b srn=%b done=%b, expected 1 0 0", err_o, sys_rst_no, done_o);
      end
      send_end(32'h0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cap_addr.size() != 4 || word_cnt_o !== 3'd4 || done_o !== 1'b0 || err_o !== 1'b1) begin
         failures++;
         $display("FAIL overflow_writes: writes=%0d cnt=%0d done=%b err=%b, expected 4 4 0 1",
                  cap_addr.size(), word_cnt_o, done_o, err_o);
      end
      check_write(0, 2'd0, 32'hA000_0000);
      check_write(3, 2'd3, 32'hA000_0003);
   endtask

   task automatic test_reset_midload();
      do_reset();
      send_word(32'h1111_1111, 3);
      send_word(32'h2222_2222, 3);
      send_byte(8'h33, 3);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({we_o, addr_o, wdata_o, sys_rst_no, done_o, err_o, frame_err_o, word_cnt_o} !== '0) begin
         failures++;
         $display("FAIL midload_reset: addr=%0d wdata=%08h cnt=%0d, expected all 0",
                  addr_o, wdata_o, word_cnt_o);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      cap_addr.delete();
      cap_data.delete();
      send_word(32'h4444_5555, 3);
      check_write(0, 2'd0, 32'h4444_5555);
      checks++;
      if (word_cnt_o !== 3'd1) begin
         failures++;
         $display("FAIL midload_restart_cnt: cnt=%0d, expected 1", word_cnt_o);
      end
   endtask

`ifdef ICCM_BOOT_CHECKSUM_EN
   task automatic test_checksum();
      do_reset();
      send_word(32'd1, 3);
      send_word(32'd2, 3);
      send_word(32'h0000_0FFF, 3);
      send_final(32'd3);
      checks++;
      if (done_o !== 1'b1 || err_o !== 1'b0 || sys_rst_no !== 1'b1) begin
         failures++;
         $display("FAIL csum_good: done=%b err=%b srn=%b, expected 1 0 1", done_o, err_o, sys_rst_no);
      end
      do_reset();
      send_word(32'd1, 3);
      send_word(32'd2, 3);
      send_word(32'h0000_0FFF, 3);
      send_final(32'd4);
      checks++;
      if (done_o !== 1'b0 || err_o !== 1'b1 || sys_rst_no !== 1'b0) begin
         failures++;
         $display("FAIL csum_bad: done=%b err=%b srn=%b, expected 0 1 0", done_o, err_o, sys_rst_no);
      end
   endtask
`endif

   initial begin
      fork
         begin
            test_reset();
            test_basic();
            test_back_to_back();
            test_timeout();
            test_overflow();
            test_reset_midload();
`ifdef ICCM_BOOT_CHECKSUM_EN
            test_checksum();
`endif
         end
         begin
            #200000;
            failures++;
            $display("FAIL watchdog: simulation time limit reached");
         end
      join_any
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iccm_boot_loader.md
Name: iccm_boot_loader

Overview:
- UART-driven boot loader that sits directly upstream of the instruction memory (ICCM).
- Consumes the received-byte stream from the UART receiver, packs the bytes little-endian into 32-bit words, and writes them sequentially into the ICCM write port.
- Holds the core/system reset asserted until an end-of-program marker arrives, then releases it so the core boots from the ICCM base address.

Parameters:
- AddrW, 12, ICCM word-address width; depth = 2**AddrW words.
- EndMarker, 32'h0000_0FFF, word value that terminates the load; this word is never written.
- TimeoutCycles, 100000, maximum clock cycles between bytes of a partially assembled word.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_dv_i  input  1  single-cycle strobe: rx_byte_i is valid.
- rx_byte_i  input  8  received UART byte.
- we_o  output  1  ICCM write enable, single-cycle pulse.
- addr_o  output  AddrW  ICCM word address.
- wdata_o  output  32  ICCM write data.
- sys_rst_no  output  1  active-low system reset to the core and fabric; low while loading.
- done_o  output  1  load completed successfully (sticky).
- err_o  output  1  load aborted on overflow or checksum failure (sticky).
- frame_err_o  output  1  at least one partial word was dropped on timeout (sticky).
- word_cnt_o  output  AddrW+1  number of words written so far.

Behaviour:
- Reset values: we_o=0, addr_o=0, wdata_o=0, sys_rst_no=0, done_o=0, err_o=0, frame_err_o=0, word_cnt_o=0. Internal byte_cnt=0 and state=LOAD.
- Reset is asynchronous. Assertion mid-load returns all state to reset values immediately; previously written ICCM contents are not cleared.
- States: LOAD, WRITE, DONE, ERR.
- LOAD:
  - On each rx_dv_i, the byte is shifted into an assembly register at lane byte_cnt (byte 0 goes to bits [7:0]), and byte_cnt increments.
  - When the 4th byte is accepted (cycle N):
    - If the assembled word equals EndMarker: go to DONE at N+1 (with CHECKSUM_EN, go to the checksum stage instead).
    - Else if word_cnt == 2**AddrW: go to ERR at N+1; the word is not written.
    - Else: go to WRITE.
  - byte_cnt wraps 3 -> 0.
- WRITE:
  - Lasts one cycle (N+1): we_o=1, addr_o = current address, wdata_o = assembled word.
  - At N+2: addr_o increments (wraps to 0 after 2**AddrW-1, but the overflow check above prevents reuse), word_cnt increments, state returns to LOAD.
  - An rx_dv_i arriving during WRITE is accepted as byte 0 of the next word; it is not lost.
  - Minimum supported byte spacing is 2 cycles.
- Timeout:
  - A counter runs in LOAD while byte_cnt != 0 and clears on each rx_dv_i.
  - When it reaches TimeoutCycles: byte_cnt is set to 0, the partial word is discarded, frame_err_o is set, and loading continues.
  - There is no timeout while byte_cnt == 0.
- DONE:
  - sys_rst_no=1 and done_o=1 from the cycle after the marker's last byte.
  - Further rx_dv_i are ignored.
  - Exit is by reset only.
- ERR:
  - sys_rst_no stays 0 and err_o=1.
  - rx_dv_i is ignored.
  - Exit is by reset only.
- we_o is never asserted outside WRITE, and never in DONE or ERR.
- word_cnt_o always equals the number of we_o pulses issued since reset.

Optional Feature:
- Macro: ICCM_BOOT_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (modulo 2**32) is kept of every written word.
  - After EndMarker, the next 4 bytes form a checksum word (same little-endian packing, same timeout rule).
  - If the checksum word equals the running sum: go to DONE. Otherwise: go to ERR.
  - Entering DONE takes one cycle after the checksum's last byte.
- Not defined: EndMarker goes directly to DONE; no sum logic is present.

Test Plan:
- Send bytes 78 56 34 12, EF BE AD DE, FF 0F 00 00 -> we_o pulses with (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF); done_o=1, sys_rst_no=1 one cycle after the final byte; word_cnt_o=2.
- Send bytes at 2-cycle spacing for 3 words plus the marker -> all 3 words written at addresses 0-2 with no byte dropped.
- Send 2 bytes, idle TimeoutCycles cycles, then a full word AA BB CC DD -> frame_err_o=1; 0xDDCCBBAA written at addr 0.
- With AddrW=2, send 5 non-marker words -> 4 writes at addresses 0-3; 5th word gives err_o=1 with no 5th we_o; sys_rst_no stays 0.
- Assert reset after 2 words and 1 byte -> all outputs return to reset values; the next word is written at addr 0.
- With ICCM_BOOT_CHECKSUM_EN: words 1 and 2, marker, checksum 3 -> done_o=1. Repeat with checksum 4 -> err_o=1, sys_rst_no=0.
